// File: rtl/cpu_scoreboard.sv
// Register-hazard scoreboard between fetch and decode: counts in-flight writes per
// architectural register and releases a tagged candidate once its operands are clean.
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module cpu_scoreboard #(
    parameter int MAX_PER_REG = 3,
    parameter int MAX_TOTAL   = 4,
    parameter int TAG_SIZE    = `TAG_SIZE
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_stall,
    input  logic                           i_flush,
    input  logic [TAG_SIZE-1:0]            i_tag,
    input  logic [4:0]                     i_rs1,
    input  logic [4:0]                     i_rs2,
    input  logic [4:0]                     i_rd,
    input  logic                           i_writes_rd,
    input  logic                           i_retire_valid,
    input  logic [4:0]                     i_retire_rd,
    output logic [TAG_SIZE-1:0]            o_tag,
    output logic                           o_stall,
    output logic                           o_busy,
    output logic [$clog2(MAX_TOTAL+1)-1:0] o_inflight,
    output logic                           o_error
);

    localparam int CW = $clog2(MAX_PER_REG + 1);
    localparam int TW = $clog2(MAX_TOTAL + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PER_REG);
    localparam logic [TW-1:0] TOT_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TOT_ONE  = TW'(1);
    localparam logic [TW-1:0] TOT_MAX  = TW'(MAX_TOTAL);

    // Entry 0 is never written, so x0 reads as permanently free.
    logic [CW-1:0]       r_cnt [0:31];
    logic [TW-1:0]       r_inflight;
    logic [TAG_SIZE-1:0] r_tag;
    logic                r_error;

    logic w_pending;
    logic w_rs1_hz;
    logic w_rs2_hz;
    logic w_rd_full;
    logic w_hazard;
    logic w_issue;
    logic w_inc;
    logic w_dec_req;
    logic w_underflow;
    logic w_dec;

    // Hazard and issue decisions from registered counts only (no retire bypass).
    always_comb begin
        w_pending = (i_tag != r_tag);
        if (i_rs1 != 5'd0) begin
            w_rs1_hz = (r_cnt[i_rs1] != CNT_ZERO);
        end else begin
            w_rs1_hz = 1'b0;
        end
        if (i_rs2 != 5'd0) begin
            w_rs2_hz = (r_cnt[i_rs2] != CNT_ZERO);
        end else begin
            w_rs2_hz = 1'b0;
        end
        if (i_writes_rd && (i_rd != 5'd0)) begin
            w_rd_full = (r_cnt[i_rd] == CNT_MAX) || (r_inflight == TOT_MAX);
        end else begin
            w_rd_full = 1'b0;
        end
        w_hazard    = w_rs1_hz || w_rs2_hz || w_rd_full;
        w_issue     = w_pending && !w_hazard && !i_stall && !i_flush;
        w_inc       = w_issue && i_writes_rd && (i_rd != 5'd0);
        w_dec_req   = i_retire_valid && (i_retire_rd != 5'd0) && !i_flush;
        w_underflow = w_dec_req && (r_cnt[i_retire_rd] == CNT_ZERO);
        w_dec       = w_dec_req && !w_underflow;
    end

    // Per-register and total outstanding-write counters.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
            r_inflight <= TOT_ZERO;
        end else if (i_flush) begin
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
            r_inflight <= TOT_ZERO;
        end else begin
            for (int i = 0; i < 32; i++) begin
                case ({w_inc && (i_rd == 5'(i)), w_dec && (i_retire_rd == 5'(i))})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNT_ONE;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            case ({w_inc, w_dec})
                2'b10:   r_inflight <= r_inflight + TOT_ONE;
                2'b01:   r_inflight <= r_inflight - TOT_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Issued tag and sticky underflow flag; flush holds the tag and keeps the error.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tag   <= {TAG_SIZE{1'b0}};
            r_error <= 1'b0;
        end else begin
            if (w_issue) begin
                r_tag <= i_tag;
            end else begin
                r_tag <= r_tag;
            end
            if (w_underflow) begin
                r_error <= 1'b1;
            end else begin
                r_error <= r_error;
            end
        end
    end

    assign o_tag      = r_tag;
    assign o_inflight = r_inflight;
    assign o_error    = r_error;
    assign o_busy     = (r_inflight != TOT_ZERO);
    assign o_stall    = w_pending && w_hazard;

endmodule
